// File: rtl/freq_meter_pkg.sv
// Shared constants and helpers for the four-channel frequency meter.
package freq_meter_pkg;

    localparam int unsigned NUM_CH       = 4;
    localparam int unsigned DEF_GATE_LEN = 16777216;
    localparam int unsigned DEF_CNT_W    = 16;

    // Number of bits needed to hold values 0..v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/freq_meter_ch.sv
// One measurement channel: input synchronizer, rising-edge detect,
// saturating edge counter with sticky overflow, and the output latch.
module freq_meter_ch
    import freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             latch,
    input  logic             sig_i,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o
);

    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] c_q, c_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             oflag_q, oflag_d;
    logic             rise;
    logic             sat;
    logic             hit;

    // Synchronizer and edge history run independently of en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Counter update; on the latch cycle the current edge is folded
    // straight into the latched value so it is neither lost nor carried over.
    always_comb begin
        rise    = s2_q & ~s3_q;
        sat     = &c_q;
        hit     = rise & sat;
        c_d     = c_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        oflag_d = oflag_q;
        if (clr) begin
            c_d   = '0;
            ovf_d = 1'b0;
        end else if (latch) begin
            count_d = hit ? c_q : c_q + CNT_W'(rise);
            oflag_d = ovf_q | hit;
            c_d     = '0;
            ovf_d   = 1'b0;
        end else if (en && rise) begin
            if (sat) begin
                ovf_d = 1'b1;
            end else begin
                c_d = c_q + CNT_W'(1);
            end
        end
    end

    // Counter, sticky overflow and latched outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q     <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            oflag_q <= 1'b0;
        end else begin
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            oflag_q <= oflag_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = oflag_q;

endmodule

// File: rtl/freq_meter4.sv
// Four-channel frequency meter: counts rising edges of each input over a
// gate window of GATE_LEN clk cycles and latches the per-channel counts.
module freq_meter4
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_LEN = DEF_GATE_LEN,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       sig_in,
    output logic [NUM_CH*CNT_W-1:0] counts,
    output logic                    valid,
    output logic [NUM_CH-1:0]       overflow
);

    localparam int unsigned   TW     = clog2(GATE_LEN);
    localparam logic [TW-1:0] T_LAST = TW'(GATE_LEN - 1);

    logic [TW-1:0] t_q, t_d;
    logic          valid_q;
    logic          latch_w;

    // Gate timer: held at 0 while disabled, wraps after the latch cycle.
    always_comb begin
        latch_w = en && (t_q == T_LAST);
        t_d     = '0;
        if (en && !latch_w) begin
            t_d = t_q + TW'(1);
        end
    end

    // Timer state and one-cycle valid pulse following each latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            t_q     <= t_d;
            valid_q <= latch_w;
        end
    end

    assign valid = valid_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        freq_meter_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .clr     (~en),
            .latch   (latch_w),
            .sig_i   (sig_in[i]),
            .count_o (counts[i*CNT_W +: CNT_W]),
            .ovf_o   (overflow[i])
        );
    end

endmodule

// File: tb/tb_freq_meter4.sv
// Directed bench for freq_meter4: instance A (GATE_LEN=100, CNT_W=16) and
// instance B (GATE_LEN=100, CNT_W=4) share clock and reset.
module tb_freq_meter4;

    logic        clk;
    logic        reset;
    logic        en_a, en_b;
    logic [7:0]  sig;
    logic [63:0] counts_a;
    logic [15:0] counts_b;
    logic        valid_a, valid_b;
    logic [3:0]  ov_a, ov_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int unsigned hp [8];
    int unsigned ph [8];

    freq_meter4 #(.GATE_LEN(100), .CNT_W(16)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .en       (en_a),
        .sig_in   (sig[3:0]),
        .counts   (counts_a),
        .valid    (valid_a),
        .overflow (ov_a)
    );

    freq_meter4 #(.GATE_LEN(100), .CNT_W(4)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .en       (en_b),
        .sig_in   (sig[7:4]),
        .counts   (counts_b),
        .valid    (valid_b),
        .overflow (ov_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Square-wave generators: bit i toggles every hp[i] negedges when hp[i] != 0.
    initial begin
        for (int i = 0; i < 8; i++) begin
            hp[i] = 0;
            ph[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (hp[i] != 0) begin
                    if (ph[i] + 1 >= hp[i]) begin
                        sig[i] = ~sig[i];
                        ph[i]  = 0;
                    end else begin
                        ph[i]++;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_gen(input int ch, input int unsigned half, input logic lvl);
        hp[ch]  = half;
        ph[ch]  = 0;
        sig[ch] = lvl;
    endtask

    // Returns the number of negedges until valid is seen, 0 on timeout.
    task automatic wait_valid(input bit use_b, input int maxc, output int k);
        k = 0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if ((use_b ? valid_b : valid_a) === 1'b1) begin
                k = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if (counts_a !== 64'h0) begin n_fail++; $display("FAIL reset_counts_a: got %h expected 0", counts_a); end
        n_checks++;
        if (ov_a !== 4'h0) begin n_fail++; $display("FAIL reset_ovf_a: got %b expected 0000", ov_a); end
        n_checks++;
        if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %b expected 0", valid_a); end
        n_checks++;
        if (counts_b !== 16'h0) begin n_fail++; $display("FAIL reset_counts_b: got %h expected 0", counts_b); end
        n_checks++;
        if (ov_b !== 4'h0) begin n_fail++; $display("FAIL reset_ovf_b: got %b expected 0000", ov_b); end
        n_checks++;
        if (valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b: got %b expected 0", valid_b); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle_gate;
        int k;
        en_a = 1'b1;
        wait_valid(1'b0, 150, k);
        n_checks++;
        if (k !== 100) begin n_fail++; $display("FAIL idle_first_valid: got cycle %0d expected 100", k); end
        n_checks++;
        if (counts_a !== 64'h0) begin n_fail++; $display("FAIL idle_counts: got %h expected 0", counts_a); end
        n_checks++;
        if (ov_a !== 4'h0) begin n_fail++; $display("FAIL idle_ovf: got %b expected 0000", ov_a); end
        @(negedge clk);
        n_checks++;
        if (valid_a !== 1'b0) begin n_fail++; $display("FAIL idle_valid_width: got %b expected 0", valid_a); end
        wait_valid(1'b0, 150, k);
        n_checks++;
        if (k !== 99) begin n_fail++; $display("FAIL idle_second_valid: got cycle %0d expected 99", k); end
    endtask

    task automatic test_rates;
        int k;
        set_gen(0, 5, 1'b0);
        set_gen(1, 10, 1'b0);
        set_gen(2, 25, 1'b0);
        set_gen(3, 50, 1'b0);
        wait_valid(1'b0, 150, k);
        wait_valid(1'b0, 150, k);
        n_checks++;
        if (k !== 100) begin n_fail++; $display("FAIL rates_period: got cycle %0d expected 100", k); end
        n_checks++;
        if (counts_a[15:0] !== 16'd10) begin n_fail++; $display("FAIL rates_ch0: got %0d expected 10", counts_a[15:0]); end
        n_checks++;
        if (counts_a[31:16] !== 16'd5) begin n_fail++; $display("FAIL rates_ch1: got %0d expected 5", counts_a[31:16]); end
        n_checks++;
        if (counts_a[47:32] !== 16'd2) begin n_fail++; $display("FAIL rates_ch2: got %0d expected 2", counts_a[47:32]); end
        n_checks++;
        if (counts_a[63:48] !== 16'd1) begin n_fail++; $display("FAIL rates_ch3: got %0d expected 1", counts_a[63:48]); end
        n_checks++;
        if (ov_a !== 4'h0) begin n_fail++; $display("FAIL rates_ovf: got %b expected 0000", ov_a); end
        for (int i = 0; i < 4; i++) set_gen(i, 0, 1'b0);
        en_a = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_latch_boundary;
        en_a = 1'b1;
        repeat (97) @(negedge clk);
        sig[0] = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (valid_a !== 1'b1) begin n_fail++; $display("FAIL boundary_valid1: got %b expected 1", valid_a); end
        n_checks++;
        if (counts_a[15:0] !== 16'd1) begin n_fail++; $display("FAIL boundary_count1: got %0d expected 1", counts_a[15:0]); end
        n_checks++;
        if (counts_a[63:16] !== 48'h0) begin n_fail++; $display("FAIL boundary_others: got %h expected 0", counts_a[63:16]); end
        repeat (10) @(negedge clk);
        sig[0] = 1'b0;
        repeat (40) @(negedge clk);
        sig[0] = 1'b1;
        repeat (10) @(negedge clk);
        sig[0] = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++;
        if (valid_a !== 1'b1) begin n_fail++; $display("FAIL boundary_valid2: got %b expected 1", valid_a); end
        n_checks++;
        if (counts_a[15:0] !== 16'd1) begin n_fail++; $display("FAIL boundary_count2: got %0d expected 1", counts_a[15:0]); end
    endtask

    task automatic test_en_drop;
        int k;
        int vcnt;
        set_gen(0, 5, 1'b0);
        repeat (50) @(negedge clk);
        en_a = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (valid_a === 1'b1) vcnt++;
        end
        n_checks++;
        if (vcnt !== 0) begin n_fail++; $display("FAIL endrop_no_valid: got %0d pulses expected 0", vcnt); end
        n_checks++;
        if (counts_a !== 64'h1) begin n_fail++; $display("FAIL endrop_counts_held: got %h expected 1", counts_a); end
        en_a = 1'b1;
        wait_valid(1'b0, 150, k);
        n_checks++;
        if (k !== 100) begin n_fail++; $display("FAIL endrop_reenable_valid: got cycle %0d expected 100", k); end
        n_checks++;
        if (counts_a[15:0] !== 16'd10) begin n_fail++; $display("FAIL endrop_count: got %0d expected 10", counts_a[15:0]); end
    endtask

    task automatic test_overflow;
        int k;
        en_b = 1'b1;
        set_gen(4, 2, 1'b0);
        set_gen(5, 10, 1'b0);
        wait_valid(1'b1, 150, k);
        wait_valid(1'b1, 150, k);
        n_checks++;
        if (k !== 100) begin n_fail++; $display("FAIL ovf_period: got cycle %0d expected 100", k); end
        n_checks++;
        if (counts_b[3:0] !== 4'd15) begin n_fail++; $display("FAIL ovf_count_ch0: got %0d expected 15", counts_b[3:0]); end
        n_checks++;
        if (ov_b !== 4'b0001) begin n_fail++; $display("FAIL ovf_flags: got %b expected 0001", ov_b); end
        n_checks++;
        if (counts_b[7:4] !== 4'd5) begin n_fail++; $display("FAIL ovf_count_ch1: got %0d expected 5", counts_b[7:4]); end
        n_checks++;
        if (counts_b[15:8] !== 8'h0) begin n_fail++; $display("FAIL ovf_count_ch23: got %h expected 0", counts_b[15:8]); end
        set_gen(4, 0, 1'b0);
        set_gen(5, 0, 1'b0);
        en_b = 1'b0;
    endtask

    task automatic test_reset_mid;
        int k;
        set_gen(0, 0, 1'b1);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (counts_a !== 64'h0) begin n_fail++; $display("FAIL rstmid_counts_a: got %h expected 0", counts_a); end
        n_checks++;
        if (ov_a !== 4'h0) begin n_fail++; $display("FAIL rstmid_ovf_a: got %b expected 0000", ov_a); end
        n_checks++;
        if (valid_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid_a: got %b expected 0", valid_a); end
        n_checks++;
        if (counts_b !== 16'h0) begin n_fail++; $display("FAIL rstmid_counts_b: got %h expected 0", counts_b); end
        n_checks++;
        if (ov_b !== 4'h0) begin n_fail++; $display("FAIL rstmid_ovf_b: got %b expected 0000", ov_b); end
        reset = 1'b0;
        wait_valid(1'b0, 150, k);
        n_checks++;
        if (k !== 100) begin n_fail++; $display("FAIL rstmid_first_valid: got cycle %0d expected 100", k); end
        n_checks++;
        if (counts_a !== 64'h1) begin n_fail++; $display("FAIL rstmid_startup_edge: got %h expected 1", counts_a); end
        n_checks++;
        if (ov_a !== 4'h0) begin n_fail++; $display("FAIL rstmid_ovf_after: got %b expected 0000", ov_a); end
    endtask

    initial begin
        reset = 1'b1;
        en_a  = 1'b0;
        en_b  = 1'b0;
        sig   = 8'h00;
        test_reset;
        test_idle_gate;
        test_rates;
        test_latch_boundary;
        test_en_drop;
        test_overflow;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_meter4.md
# freq_meter4

Four-channel frequency meter: measures the rising-edge rate of four slow, asynchronous square-wave inputs (LED-rate divider taps, switch or external pulse sources). It counts rising edges over a fixed gate window of clk cycles and latches one count per channel at the end of each window. It is the measuring counterpart to the team's clock-divider generators and sits between board inputs and the display/readout logic.

## Interface
- GATE_LEN, 16777216: gate window length in clk cycles, ≥ 4.
- CNT_W, 16: per-channel count width.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clock clk.
- en  in  1  measurement enable.
- sig_in  in  4  asynchronous input signals, channel i = sig_in[i].
- counts  out  4*CNT_W  latched counts; channel i at [i*CNT_W +: CNT_W].
- valid  out  1  one-cycle pulse: counts/overflow updated.
- overflow  out  4  per-channel saturation flag for the last latched window.

## Operation
- Per channel: 2-flop synchronizer s1→s2, history flop s3; edge = s2 & ~s3. s1/s2/s3 reset to 0, and run regardless of en.
- Gate timer t (width clog2(GATE_LEN)) counts 0..GATE_LEN-1 while en=1 and wraps to 0.
- Per-channel counter c increments on edge while en=1. It saturates at 2^CNT_W-1 and sets a sticky ovf bit when an edge arrives at saturation.
- Latch cycle (en=1, t=GATE_LEN-1):
  - counts[i] <= c[i] + edge[i], saturated.
  - overflow[i] <= ovf[i] or (saturation hit in this cycle).
  - c and ovf clear to 0; valid <= 1 on the next cycle only.
- en=0: t, c and ovf are held at 0. counts/overflow keep their last latched values; valid=0.
- en rising: the window starts with t=0 on the first cycle en=1 is sampled.
- Inputs need ≥ 2 clk high and ≥ 2 clk low per period to be counted exactly; faster inputs are undercounted, with no error flag.
- Startup: an input already high when reset releases counts as one edge, because s3 resets to 0.

## Timing
- Reset values: counts=0, overflow=0, valid=0, t=0, c=0.
- An input rise first sampled by s1 at clk edge k: s2=1 at k+1, edge asserted during cycle k+1→k+2, c increments at edge k+2.
- An increment coinciding with the latch edge is included in that window's count; none is lost or double-counted across windows.
- valid is high during the cycle after the latch edge, exactly once per GATE_LEN cycles while en=1. The first valid comes GATE_LEN cycles after en is sampled high.
- Reset mid-window: the window is discarded, all state returns to reset values, and counting restarts on the first en=1 cycle after release.
- en deasserted mid-window: partial counts are discarded, no valid is produced, and counts are unchanged.

## Structure
- Shared package freq_meter_pkg: NUM_CH=4, default GATE_LEN and CNT_W, and a clog2 function for the timer width.
- Sub-module freq_meter_ch holds one channel: synchronizer, edge detect, saturating counter, ovf, and output latch. It has inputs clr, latch and en. It is instantiated 4× by a generate loop.
- The top holds the gate timer and the valid register.

## Test plan
- Reset then en=1 with GATE_LEN=100 and all inputs low → valid pulses every 100 cycles; counts=0, overflow=0.
- GATE_LEN=100, sig_in[0] period 10 clk (5 high/5 low), sig_in[1] period 20, sig_in[2] period 50, sig_in[3] period 100 → steady-state counts 10/5/2/1.
- An edge timed so that c increments exactly on the latch edge → it is counted in the current window, and the next window count is still exact.
- CNT_W=4, GATE_LEN=100, sig_in[0] period 4 → counts[0]=15 and overflow[0]=1; other channels are unaffected.
- en dropped at t=50 and reasserted → no valid, counts unchanged; the next valid arrives 100 cycles after re-enable.
- Reset asserted mid-window with sig_in[0] held high → all outputs 0. After release, the first window counts exactly 1 edge on channel 0.
